// File: rtl/channel_readout_sequencer_pkg.sv
// Shared constants for the channel readout sequencer: state encoding, default
// slice widths, and a constant clog2 helper.
package channel_readout_sequencer_pkg;

    localparam int DEF_WIDTH = 12;
    localparam int DEF_SIZE  = 12;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_LAT     = 3'd2;
    localparam logic [2:0] ST_XFER    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/channel_readout_sequencer_mask_next_select.sv
// Holds the active channel index and finds the lowest mask bit (pass start)
// and the next set mask bit above the current index, with a "none" flag.
module mask_next_select
    import channel_readout_sequencer_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int IW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             first_i,
    input  logic             adv_i,
    input  logic [NCHAN-1:0] first_mask_i,
    input  logic [NCHAN-1:0] mask_i,
    output logic [IW-1:0]    idx_o,
    output logic [IW-1:0]    idx_d_o,
    output logic             none_o
);

    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic [IW-1:0] low_s;
    logic [IW-1:0] nxt_s;
    logic          none_s;

    // Priority search: descending loops so the lowest qualifying bit wins.
    always_comb begin
        low_s  = '0;
        nxt_s  = '0;
        none_s = 1'b1;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            low_s  = first_mask_i[i] ? IW'(i) : low_s;
            nxt_s  = (mask_i[i] && (i > int'(idx_q))) ? IW'(i) : nxt_s;
            none_s = (mask_i[i] && (i > int'(idx_q))) ? 1'b0 : none_s;
        end
    end

    // Next index selection.
    always_comb begin
        if (first_i) begin
            idx_d = low_s;
        end else if (adv_i) begin
            idx_d = nxt_s;
        end else begin
            idx_d = idx_q;
        end
    end

    // Index register.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o   = idx_q;
    assign idx_d_o = idx_d;
    assign none_o  = none_s;

endmodule

// File: rtl/channel_readout_sequencer.sv
// Grants each masked channel in turn, steps its read address per accepted word
// and merges all words into one stream. Watchdog: CHANNEL_READOUT_SEQUENCER_TIMEOUT_EN.
module channel_readout_sequencer
    import channel_readout_sequencer_pkg::*;
#(
    parameter int NCHAN  = 4,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SIZE   = DEF_SIZE,
    parameter int RD_LAT = 2,
`ifdef CHANNEL_READOUT_SEQUENCER_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 1024,
`endif
    localparam int IW = (clog2(NCHAN) > 0) ? clog2(NCHAN) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NCHAN-1:0]       chan_mask,
    input  logic [SIZE-1:0]        how_many,
    input  logic [NCHAN-1:0]       ch_ro_enable,
    input  logic [NCHAN-1:0]       ch_rodone_n,
    input  logic [NCHAN*WIDTH-1:0] ch_data,
    output logic [NCHAN-1:0]       ch_read_request,
    output logic [NCHAN-1:0]       ch_spi_done,
    output logic [WIDTH-1:0]       out_data,
    output logic [IW-1:0]          out_chan,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   out_frame_end,
    output logic                   busy,
    output logic                   done,
    output logic [NCHAN-1:0]       err_timeout
);

    localparam int LW = (clog2(RD_LAT + 1) > 0) ? clog2(RD_LAT + 1) : 1;
    localparam logic [LW-1:0] LAT_LOAD = LW'(RD_LAT);

    logic [2:0]       state_q, state_d;
    logic [NCHAN-1:0] mask_q, mask_d;
    logic [SIZE-1:0]  hm_q, hm_d;
    logic [SIZE-1:0]  word_cnt_q, word_cnt_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [IW-1:0]    out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             out_fe_q, out_fe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [NCHAN-1:0] req_q, req_d;
    logic [NCHAN-1:0] spi_q, spi_d;
    logic [NCHAN-1:0] err_q, err_d;
    logic             sel_first_s, chan_end_s, sel_adv_s, none_s, tmo_s;
    logic [IW-1:0]    idx_s, idx_nxt_s;
    logic [2:0]       after_chan_s;

    mask_next_select #(.NCHAN(NCHAN), .IW(IW)) u_sel (
        .clk          (clk),
        .reset        (reset),
        .first_i      (sel_first_s),
        .adv_i        (sel_adv_s),
        .first_mask_i (chan_mask),
        .mask_i       (mask_q),
        .idx_o        (idx_s),
        .idx_d_o      (idx_nxt_s),
        .none_o       (none_s)
    );

    assign after_chan_s = none_s ? ST_DONE : ST_REQ;
    assign sel_adv_s    = chan_end_s && !none_s;

    // Sequencer next-state and datapath.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        hm_d        = hm_q;
        word_cnt_d  = word_cnt_q;
        lat_d       = lat_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_fe_d    = out_fe_q;
        spi_d       = '0;
        err_d       = err_q;
        sel_first_s = 1'b0;
        chan_end_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d      = chan_mask;
                    hm_d        = how_many;
                    word_cnt_d  = '0;
                    sel_first_s = 1'b1;
                    state_d     = ((chan_mask == '0) || (how_many == '0)) ? ST_DONE : ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                err_d[idx_s] = err_q[idx_s] | tmo_s;
                if (tmo_s) begin
                    chan_end_s = 1'b1;
                    word_cnt_d = '0;
                    state_d    = after_chan_s;
                end else if (ch_ro_enable[idx_s]) begin
                    lat_d   = LAT_LOAD;
                    state_d = ST_LAT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_LAT: begin
                if (lat_q == '0) begin
                    out_data_d  = ch_data[int'(idx_s)*WIDTH +: WIDTH];
                    out_chan_d  = idx_s;
                    out_valid_d = 1'b1;
                    out_last_d  = (word_cnt_q == (hm_q - SIZE'(1)));
                    out_fe_d    = (word_cnt_q == (hm_q - SIZE'(1))) && none_s;
                    state_d     = ST_XFER;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            ST_XFER: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    spi_d[idx_s] = 1'b1;
                    word_cnt_d   = word_cnt_q + SIZE'(1);
                    lat_d        = LAT_LOAD;
                    state_d      = out_last_q ? ST_RELEASE : ST_LAT;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_RELEASE: begin
                err_d[idx_s] = err_q[idx_s] | tmo_s;
                if (tmo_s || !ch_ro_enable[idx_s] || !ch_rodone_n[idx_s]) begin
                    chan_end_s = 1'b1;
                    word_cnt_d = '0;
                    state_d    = after_chan_s;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The request follows the index the sequencer is about to hold next cycle.
    assign req_d  = ((state_d == ST_REQ) || (state_d == ST_LAT) || (state_d == ST_XFER))
                    ? (NCHAN'(1) << idx_nxt_s) : '0;
    assign busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    assign done_d = (state_d == ST_DONE);

`ifdef CHANNEL_READOUT_SEQUENCER_TIMEOUT_EN
    localparam int WDW = clog2(TIMEOUT_CYC) + 1;
    logic [WDW-1:0] wd_q, wd_d;

    assign tmo_s = ((state_q == ST_REQ) || (state_q == ST_RELEASE))
                   && (wd_q == WDW'(TIMEOUT_CYC - 1));

    // Watchdog counts consecutive waiting cycles, restarting on any progress.
    always_comb begin
        if (chan_end_s || (state_d != state_q)) begin
            wd_d = '0;
        end else if ((state_q == ST_REQ) || (state_q == ST_RELEASE)) begin
            wd_d = wd_q + WDW'(1);
        end else begin
            wd_d = '0;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign tmo_s = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            hm_q        <= '0;
            word_cnt_q  <= '0;
            lat_q       <= '0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_fe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_q       <= '0;
            spi_q       <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            hm_q        <= hm_d;
            word_cnt_q  <= word_cnt_d;
            lat_q       <= lat_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_fe_q    <= out_fe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_q       <= req_d;
            spi_q       <= spi_d;
            err_q       <= err_d;
        end
    end

    assign ch_read_request = req_q;
    assign ch_spi_done     = spi_q;
    assign out_data        = out_data_q;
    assign out_chan        = out_chan_q;
    assign out_valid       = out_valid_q;
    assign out_last        = out_last_q;
    assign out_frame_end   = out_fe_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err_timeout     = err_q;

endmodule

// File: doc/channel_readout_sequencer.md
Name: channel_readout_sequencer

Overview:
- Sequences readout of NCHAN single-channel digitizer slices (ring buffer plus address control) after a trigger.
- Grants read_request to one channel at a time and steps that channel's read address by pulsing its SPI_done per accepted word.
- Merges all channel words into one valid/ready stream that feeds the SPI/host readout path.
- Sits between the per-channel array and the readout serializer.

Parameters:
- NCHAN, 4, number of channels sequenced.
- WIDTH, 12, sample width.
- SIZE, 12, ring buffer address/count width.
- RD_LAT, 2, sysclk cycles from address advance to valid ch_data.
- TIMEOUT_CYC, 1024, watchdog limit (optional feature only).

Ports:
- clk  in  1  system clock (all channel control logic runs on it).
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that begins a readout pass.
- chan_mask  in  NCHAN  1 = channel included in the pass.
- how_many  in  SIZE  words per channel.
- ch_ro_enable  in  NCHAN  per-channel RO_ENABLE.
- ch_rodone_n  in  NCHAN  per-channel RODONE_n.
- ch_data  in  NCHAN*WIDTH  per-channel data_out; channel i is bits [i*WIDTH +: WIDTH].
- ch_read_request  out  NCHAN  one-hot or zero.
- ch_spi_done  out  NCHAN  one-cycle address-advance pulses.
- out_data  out  WIDTH  stream word.
- out_chan  out  clog2(NCHAN)  source channel of out_data.
- out_valid  out  1
- out_ready  in  1
- out_last  out  1  marks the final word of the current channel.
- out_frame_end  out  1  marks the final word of the pass.
- busy  out  1
- done  out  1  one-cycle pulse at end of pass.
- err_timeout  out  NCHAN  sticky per-channel timeout flags.

Behaviour:
- Reset:
  - Clock: clk only. reset is synchronous and active-high.
  - Reset forces state IDLE.
  - All outputs go to 0, including err_timeout.
  - Reset mid-pass takes effect at the next edge: read_request drops and no done pulse is issued.
- States: IDLE, REQ, LAT, XFER, RELEASE, DONE.
- IDLE:
  - On start, sample chan_mask and how_many into registers, set busy=1, and select the lowest-index set mask bit.
  - If the mask is empty or how_many==0, go to DONE with no requests.
  - start is ignored while busy=1.
- REQ:
  - ch_read_request[idx]=1. The request is held through REQ, LAT and XFER.
  - Wait for ch_ro_enable[idx]=1, then load the latency counter with RD_LAT and go to LAT.
- LAT:
  - Decrement the counter each cycle.
  - When it reaches 0, register ch_data slice idx into out_data, drive out_chan=idx, set out_valid=1 and go to XFER.
  - out_last=1 when word_cnt==how_many-1.
  - out_frame_end=out_last AND idx is the last selected channel.
- XFER:
  - out_data, out_chan, out_last and out_frame_end are stable while out_valid && !out_ready.
  - On handshake, the next edge does all of the following:
    - out_valid=0
    - ch_spi_done[idx]=1 for exactly one cycle
    - word_cnt increments
  - Then go to RELEASE if the accepted word had out_last=1, else to LAT.
  - Net throughput: at most one word per RD_LAT+2 cycles.
- RELEASE:
  - ch_read_request=0.
  - Wait until ch_ro_enable[idx]=0 or ch_rodone_n[idx]=0.
  - Then clear word_cnt and advance idx to the next set mask bit above idx, returning to REQ.
  - If no higher bit is set, go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE. A start in that cycle is ignored.
- Counter and index rules:
  - word_cnt is SIZE bits and compares equal to how_many-1; how_many == 2^SIZE-1 is legal.
  - idx never wraps within a pass.
- Invariants:
  - At most one ch_read_request bit is high.
  - ch_spi_done is only ever asserted for the channel currently holding the request.

Optional Feature:
- Macro: CHANNEL_READOUT_SEQUENCER_TIMEOUT_EN.
- Defined:
  - A watchdog counts consecutive cycles in REQ or RELEASE.
  - Reaching TIMEOUT_CYC sets err_timeout[idx], which stays set until reset.
  - The sequencer then drops the request and advances as if RELEASE had completed, so no data is emitted for the remaining words of that channel.
  - The counter clears on every state change.
- Undefined: REQ and RELEASE wait indefinitely, and err_timeout is tied to 0 (the port is still present).

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=3'd0, REQ=3'd1, LAT=3'd2, XFER=3'd3, RELEASE=3'd4, DONE=3'd5);
  - the clog2 helper function;
  - the default WIDTH and SIZE values shared with the channel slice.
- One natural sub-module, mask_next_select: combinational plus a registered index that gives the next set mask bit above the current index and a "none" flag. All remaining logic is in the top level.

Test Plan:
- Mask 4'b1111, how_many=3, out_ready=1, ch_data slice i = 12'h100*i + word -> 12 words in order (ch0 w0..w2, ch1, ..., ch3); out_last on every 3rd word; out_frame_end only on ch3 w2; 12 total ch_spi_done pulses; single done pulse.
- Mask 4'b1010 -> only channels 1 and 3 are requested; ch_read_request[0] and ch_read_request[2] never go high; out_chan sequence is 1,1,1,3,3,3.
- out_ready held low for 5 cycles on ch0 word 1 -> out_data is stable; no ch_spi_done during the stall; exactly one pulse after the handshake.
- how_many=0, or mask=0, with start -> done one cycle after IDLE exit; no requests; out_valid never asserted.
- Reset asserted in XFER of ch2 -> the next edge has all outputs 0 and no done pulse; a start two cycles later begins again at ch0.
- With the macro defined, TIMEOUT_CYC=16, and ch1 ro_enable stuck at 0 -> err_timeout=4'b0010 after 16 cycles in REQ; ch2 is then served normally; done is still pulsed.
